// File: rtl/imgproc_pkg.sv
// Shared definitions for the image-processor message path: register map,
// flush control bit, default message ID and the reader state encoding.
package imgproc_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 3;

   localparam logic [ADDR_W-1:0] REG_STATUS = 3'd0;
   localparam logic [ADDR_W-1:0] READ_MSG   = 3'd1;
   localparam logic [ADDR_W-1:0] READ_ID    = 3'd2;
   localparam logic [ADDR_W-1:0] REG_BBCOL  = 3'd3;

   localparam int unsigned FLUSH_BIT = 4;

   localparam logic [DATA_W-1:0] DEFAULT_MSG_ID = 32'h0052_4242;

   typedef enum logic [3:0] {
      IDLE,
      RD_STAT,
      WT_STAT,
      RD_ID,
      WT_ID,
      RD_PAY,
      WT_PAY,
      EMIT,
      FLUSH
   } state_t;

   // Payload word layout as delivered by the image processor
   typedef struct packed {
      logic [15:0] distance;
      logic [7:0]  angle;
      logic [7:0]  detected;
   } msg_rec_t;

endpackage

// File: rtl/imgproc_msg_reader_poll_timer.sv
// Loadable down-counter pacing status polls; stops at zero and can be held.
module imgproc_msg_reader_poll_timer #(
   parameter int unsigned           WIDTH  = 10,
   parameter logic [WIDTH-1:0]      RELOAD = '1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic hold,
   output logic zero_c
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= RELOAD;
      end else if (load) begin
         count <= RELOAD;
      end else if (!hold && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero_c = (count == '0);

endmodule

// File: rtl/imgproc_msg_reader.sv
// Avalon-MM master that polls the image processor's message buffer, reads
// two-word RBB messages, and presents decoded records or flushes on bad framing.
module imgproc_msg_reader
   import imgproc_pkg::*;
#(
   parameter int unsigned        POLL_INTERVAL = 1024,
   parameter logic [DATA_W-1:0]  MSG_ID        = DEFAULT_MSG_ID
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   output logic              m_chipselect,
   output logic              m_read,
   output logic              m_write,
   output logic [ADDR_W-1:0] m_address,
   output logic [DATA_W-1:0] m_writedata,
   input  logic [DATA_W-1:0] m_readdata,
   output logic              msg_valid,
   output logic [15:0]       msg_distance,
   output logic [7:0]        msg_angle,
   output logic [7:0]        msg_detected,
   output logic [7:0]        resync_count,
   output logic              busy
);

   localparam int unsigned       TIMER_W      = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
   localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_INTERVAL - 1);
   localparam logic [DATA_W-1:0]  FLUSH_CMD    = DATA_W'(1) << FLUSH_BIT;

   state_t     state;
   state_t     state_next;
   logic       timer_load_c;
   logic       timer_hold_c;
   logic       timer_zero_c;
   logic       usedw_ok_c;
   logic       ready_seen;
   msg_rec_t   rec;

   imgproc_msg_reader_poll_timer #(
      .WIDTH  (TIMER_W),
      .RELOAD (TIMER_RELOAD)
   ) u_poll_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (timer_load_c),
      .hold    (timer_hold_c),
      .zero_c  (timer_zero_c)
   );

   assign usedw_ok_c   = (m_readdata[15:8] >= 8'd2);
   assign timer_hold_c = !((state == IDLE) && enable);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state; reads are always separated by a wait state, so strobes never abut
   always_comb begin
      state_next   = state;
      timer_load_c = 1'b0;
      case (state)
         IDLE:    if (enable && (ready_seen || timer_zero_c)) state_next = RD_STAT;
         RD_STAT: state_next = WT_STAT;
         WT_STAT: begin
            if (!usedw_ok_c) begin
               state_next   = IDLE;
               timer_load_c = 1'b1;
            end else if (enable) begin
               state_next = RD_ID;
            end else begin
               state_next = IDLE;
            end
         end
         RD_ID:   state_next = WT_ID;
         WT_ID:   state_next = (m_readdata == MSG_ID) ? RD_PAY : FLUSH;
         RD_PAY:  state_next = WT_PAY;
         WT_PAY:  state_next = EMIT;
         EMIT:    state_next = enable ? RD_STAT : IDLE;
         FLUSH: begin
            state_next   = IDLE;
            timer_load_c = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   // Remembers whether the last poll found a full message waiting
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ready_seen <= 1'b0;
      end else if (state == WT_STAT) begin
         ready_seen <= usedw_ok_c;
      end else if (state == FLUSH) begin
         ready_seen <= 1'b0;
      end
   end

   // Bus strobes and record outputs registered from the upcoming state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         m_read       <= 1'b0;
         m_write      <= 1'b0;
         m_chipselect <= 1'b0;
         m_address    <= REG_STATUS;
         m_writedata  <= '0;
         msg_valid    <= 1'b0;
         busy         <= 1'b0;
         rec          <= '0;
         resync_count <= 8'd0;
      end else begin
         m_read       <= (state_next inside {RD_STAT, RD_ID, RD_PAY});
         m_write      <= (state_next == FLUSH);
         m_chipselect <= (state_next inside {RD_STAT, RD_ID, RD_PAY, FLUSH});
         m_address    <= (state_next inside {RD_ID, RD_PAY}) ? READ_MSG : REG_STATUS;
         m_writedata  <= (state_next == FLUSH) ? FLUSH_CMD : '0;
         msg_valid    <= (state_next == EMIT);
         busy         <= (state_next != IDLE);
         if (state == WT_PAY) begin
            rec <= msg_rec_t'(m_readdata);
         end
         if ((state_next == FLUSH) && (resync_count != 8'hFF)) begin
            resync_count <= resync_count + 8'd1;
         end
      end
   end

   assign msg_distance = rec.distance;
   assign msg_angle    = rec.angle;
   assign msg_detected = rec.detected;

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Randomized bench for imgproc_msg_reader: behavioural FIFO slave plus a
// message-list reference model predicting records, flushes and resync counts.
module tb_imgproc_msg_reader;

   localparam int unsigned PI   = 16;
   localparam logic [31:0] ID   = 32'h0052_4242;
   localparam logic [31:0] FCMD = 32'h0000_0010;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b1;
   logic        m_chipselect;
   logic        m_read;
   logic        m_write;
   logic [2:0]  m_address;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata = 32'h0;
   logic        msg_valid;
   logic [15:0] msg_distance;
   logic [7:0]  msg_angle;
   logic [7:0]  msg_detected;
   logic [7:0]  resync_count;
   logic        busy;

   imgproc_msg_reader #(
      .POLL_INTERVAL (PI),
      .MSG_ID        (ID)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .m_chipselect (m_chipselect),
      .m_read       (m_read),
      .m_write      (m_write),
      .m_address    (m_address),
      .m_writedata  (m_writedata),
      .m_readdata   (m_readdata),
      .msg_valid    (msg_valid),
      .msg_distance (msg_distance),
      .msg_angle    (msg_angle),
      .msg_detected (msg_detected),
      .resync_count (resync_count),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Slave FIFO and observation log
   logic [31:0] fifo[$];
   logic [31:0] got_rec[$];
   int          stat_t[$];
   int          valid_t[$];
   int          cyc = 0;
   int          rd_msg, rd_stat, wr_cnt, ready_t;
   int          b2b = 0, cs_bad = 0, wd_bad = 0;
   logic [31:0] last_wdata;
   logic [2:0]  last_waddr;
   logic [7:0]  last_usedw;
   logic        prev_rd = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset_n) begin
         fifo.delete();
         prev_rd = 1'b0;
      end else begin
         if (m_read) begin
            if (prev_rd) b2b++;
            if (m_address == 3'd0) begin
               last_usedw = 8'(fifo.size());
               m_readdata = {16'h0, last_usedw, 8'h0};
               rd_stat++;
               stat_t.push_back(cyc);
               if (last_usedw >= 8'd2) ready_t = cyc;
            end else if (m_address == 3'd1) begin
               rd_msg++;
               if (fifo.size() > 0) m_readdata = fifo.pop_front();
               else m_readdata = 32'h0;
            end else begin
               m_readdata = 32'hDEAD_BEEF;
            end
         end
         prev_rd = m_read;
         if (m_write) begin
            wr_cnt++;
            last_waddr = m_address;
            last_wdata = m_writedata;
            if (m_address == 3'd0 && m_writedata[4]) fifo.delete();
         end
         if (m_chipselect !== (m_read | m_write)) cs_bad++;
         if (!m_write && m_writedata !== 32'h0) wd_bad++;
         if (msg_valid) begin
            got_rec.push_back({msg_distance, msg_angle, msg_detected});
            valid_t.push_back(cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      rd_msg = 0; rd_stat = 0; wr_cnt = 0; ready_t = -1000;
      got_rec.delete(); stat_t.delete(); valid_t.delete();
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int k = 0;
      while (!(fifo.size() == 0 && !busy) && k < budget) begin
         tick(1);
         k++;
      end
      chk({tag, "_timeout"}, 32'(k < budget), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_read"}, 32'(m_read), 32'd0);
      chk({tag, "_write"}, 32'(m_write), 32'd0);
      chk({tag, "_cs"}, 32'(m_chipselect), 32'd0);
      chk({tag, "_valid"}, 32'(msg_valid), 32'd0);
      chk({tag, "_addr"}, 32'(m_address), 32'd0);
      chk({tag, "_wdata"}, m_writedata, 32'd0);
      chk({tag, "_rec"}, {msg_distance, msg_angle, msg_detected}, 32'd0);
      chk({tag, "_resync"}, 32'(resync_count), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Reference model: messages drain in order until the first bad ID, which
   // flushes everything behind it and bumps the saturating resync count.
   logic [31:0] m_id[$];
   logic [31:0] m_pay[$];
   int          exp_resync = 0;

   task automatic play(input string tag);
      logic [31:0] exp_rec[$];
      int exp_wr = 0;
      int exp_rd = 0;
      clear_log();
      foreach (m_id[i]) begin
         fifo.push_back(m_id[i]);
         fifo.push_back(m_pay[i]);
      end
      foreach (m_id[i]) begin
         exp_rd++;
         if (m_id[i] != ID) begin
            exp_wr = 1;
            if (exp_resync < 255) exp_resync++;
            break;
         end
         exp_rd++;
         exp_rec.push_back(m_pay[i]);
      end
      wait_drain(tag, 4 * PI + 20 * m_id.size() + 20);
      tick(1);
      chk({tag, "_nrec"}, 32'(got_rec.size()), 32'(exp_rec.size()));
      for (int i = 0; i < exp_rec.size() && i < got_rec.size(); i++)
         chk({tag, "_rec"}, got_rec[i], exp_rec[i]);
      chk({tag, "_nwr"}, 32'(wr_cnt), 32'(exp_wr));
      chk({tag, "_nrd"}, 32'(rd_msg), 32'(exp_rd));
      chk({tag, "_resync"}, 32'(resync_count), 32'(exp_resync));
      if (exp_wr != 0) chk({tag, "_wdata"}, last_wdata, FCMD);
      m_id.delete();
      m_pay.delete();
   endtask

   initial begin
      int rel;
      int k;
      logic [31:0] bad;

      clear_log();
      reset_n = 1'b0;
      tick(3);
      check_reset_vals("reset");

      // First poll after reset, then steady empty polling
      rel = cyc;
      reset_n = 1'b1;
      k = 0;
      while (stat_t.size() < 4 && k < 6 * (PI + 2)) begin tick(1); k++; end
      chk("poll_timeout", 32'(stat_t.size() >= 4), 32'd1);
      if (stat_t.size() >= 4) begin
         chk("first_poll", 32'(stat_t[0] - rel), 32'(PI));
         for (int i = 1; i < 4; i++)
            chk("poll_period", 32'(stat_t[i] - stat_t[i-1]), 32'(PI + 2));
      end
      chk("empty_msg_reads", 32'(rd_msg), 32'd0);
      chk("empty_valid", 32'(got_rec.size()), 32'd0);

      // Single known message
      m_id.push_back(ID); m_pay.push_back(32'h01F4_0001);
      play("single");
      if (got_rec.size() == 1) begin
         chk("single_dist", 32'(got_rec[0][31:16]), 32'd500);
         chk("single_angle", 32'(got_rec[0][15:8]), 32'd0);
         chk("single_det", 32'(got_rec[0][7:0]), 32'd1);
         chk("latency", 32'(valid_t[0] - ready_t + 1), 32'd7);
      end

      // Two messages back to back
      m_id.push_back(ID); m_pay.push_back($urandom);
      m_id.push_back(ID); m_pay.push_back($urandom);
      play("double");
      if (valid_t.size() == 2) chk("double_gap", 32'(valid_t[1] - valid_t[0]), 32'd7);
      chk("double_last_usedw", 32'(last_usedw), 32'd0);
      chk("double_idle", 32'(busy), 32'd0);

      // Bad ID triggers a flush write
      m_id.push_back(32'h0000_1234); m_pay.push_back($urandom);
      play("bad_id");
      chk("bad_id_waddr", 32'(last_waddr), 32'd0);

      // One word present: not ready
      clear_log();
      fifo.push_back(ID);
      tick(3 * (PI + 2));
      chk("usedw1_polls", 32'(rd_stat >= 2), 32'd1);
      chk("usedw1_reads", 32'(rd_msg), 32'd0);
      fifo.delete();
      tick(4);

      // Disabled reader stays parked
      enable = 1'b0;
      tick(6);
      clear_log();
      fifo.push_back(ID); fifo.push_back(32'h0010_2003);
      tick(3 * PI);
      chk("parked_reads", 32'(rd_stat + rd_msg), 32'd0);
      chk("parked_busy", 32'(busy), 32'd0);
      enable = 1'b1;
      wait_drain("unpark", 4 * PI + 40);
      tick(1);
      chk("unpark_nrec", 32'(got_rec.size()), 32'd1);
      if (got_rec.size() == 1) chk("unpark_rec", got_rec[0], 32'h0010_2003);

      // Random message lists
      for (int s = 0; s < 15; s++) begin
         int n = int'($urandom_range(1, 3));
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               do bad = $urandom; while (bad == ID);
               m_id.push_back(bad);
            end else begin
               m_id.push_back(ID);
            end
            m_pay.push_back($urandom);
         end
         play("rand");
      end

      // Saturation of the resync counter
      for (int s = 0; s < 260; s++) begin
         fifo.push_back(32'h0000_1234 + 32'(s));
         fifo.push_back($urandom);
         if (exp_resync < 255) exp_resync++;
         wait_drain("sat", 4 * PI + 40);
      end
      tick(1);
      chk("sat_resync", 32'(resync_count), 32'(exp_resync));
      chk("sat_value", 32'(resync_count), 32'hFF);

      // Reset while waiting on the ID word
      clear_log();
      fifo.push_back(ID); fifo.push_back(32'h0BAD_0BAD);
      k = 0;
      while (rd_msg == 0 && k < 4 * PI) begin tick(1); k++; end
      chk("rst_reach_wt_id", 32'(rd_msg), 32'd1);
      reset_n = 1'b0;
      tick(1);
      check_reset_vals("mid_reset");
      reset_n = 1'b1;
      exp_resync = 0;
      tick(2);
      chk("mid_reset_norec", 32'(got_rec.size()), 32'd0);
      m_id.push_back(ID); m_pay.push_back(32'h0123_4567);
      play("after_reset");

      chk("no_b2b_reads", 32'(b2b), 32'd0);
      chk("cs_rule", 32'(cs_bad), 32'd0);
      chk("wdata_rule", 32'(wd_bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imgproc_msg_reader.md
# imgproc_msg_reader

Avalon-MM master that drains the image processor's message FIFO without CPU involvement. It polls the status register, reads each two-word "RBB" message (ID word, then payload), checks the ID, and presents the decoded distance/angle/detected fields as a one-cycle-valid record to rover control logic. On a framing error it flushes the processor's message buffer and counts the resync.

## Interface
- POLL_INTERVAL, 1024: clk cycles idle between status polls when the buffer holds fewer than 2 words.
- MSG_ID, 32'h0052_4242: expected ID word ("RBB", zero-extended).
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  when low, the FSM finishes the current message and then parks in IDLE.
- m_chipselect  out  1  Avalon chipselect.
- m_read  out  1  read strobe, one-cycle pulse.
- m_write  out  1  write strobe, one-cycle pulse.
- m_address  out  3  word address: 0 status, 1 message, 2 ID.
- m_writedata  out  32  write data.
- m_readdata  in  32  read data, valid the cycle after m_read (fixed latency 1, no waitrequest).
- msg_valid  out  1  one-cycle pulse when a record is presented.
- msg_distance  out  16  payload[31:16].
- msg_angle  out  8  payload[15:8].
- msg_detected  out  8  payload[7:0].
- resync_count  out  8  saturating count of ID mismatches.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, RD_STAT, WT_STAT, RD_ID, WT_ID, RD_PAY, WT_PAY, EMIT, FLUSH.
- IDLE: the poll timer counts down from POLL_INTERVAL-1. At 0 with enable=1, go to RD_STAT. If the previous status poll showed at least 2 words, skip the timer and go directly to RD_STAT.
- RD_STAT: drive m_chipselect=1, m_read=1, m_address=0 for one cycle, then go to WT_STAT.
- WT_STAT: sample usedw = m_readdata[15:8].
  - usedw >= 2: go to RD_ID.
  - Otherwise: reload the timer and go to IDLE.
- RD_ID: issue a read at address 1, then go to WT_ID.
- WT_ID: compare m_readdata with MSG_ID.
  - Equal: go to RD_PAY.
  - Not equal: go to FLUSH.
- RD_PAY: issue a read at address 1, then go to WT_PAY.
- WT_PAY: latch m_readdata into the payload register, then go to EMIT.
- EMIT: msg_valid=1 for one cycle, then go to RD_STAT (back-to-back drain).
- FLUSH: drive m_write=1, m_address=0, m_writedata=32'h10 for one cycle. Increment resync_count, saturating at 8'hFF. Return to IDLE with the timer reloaded.
- Every read strobe is followed by at least one cycle with m_read=0. The slave pops on the rising edge of read only, so back-to-back read pulses are forbidden.
- m_chipselect equals m_read | m_write. m_writedata is 0 whenever m_write is low.
- enable low: any in-progress message runs to EMIT or FLUSH, then the FSM stays in IDLE. The timer holds its value while parked.
- msg_distance, msg_angle and msg_detected hold their last values between pulses.

## Timing
- Reset values:
  - State IDLE, timer POLL_INTERVAL-1.
  - m_read, m_write, m_chipselect and msg_valid all 0.
  - m_address 0, m_writedata 0.
  - msg_distance, msg_angle, msg_detected 0; resync_count 0; busy 0.
- Read with strobe in cycle N: data is sampled at the end of cycle N+1. The next strobe can be no earlier than N+2.
- Per-message latency, from entering RD_STAT (usedw >= 2) to msg_valid: 7 cycles (RD_STAT, WT_STAT, RD_ID, WT_ID, RD_PAY, WT_PAY, EMIT).
- Reset asserted mid-transaction: all outputs return to reset values on the next edge. No partial record is emitted. Any FIFO word already popped is lost; the slave's own reset flushes its FIFO anyway.
- usedw == 1 (a message is mid-write): treated as "not ready", back to IDLE.
- usedw is 8 bits. No wrap handling is needed because the slave caps the buffer below 256.

## Structure
- Shared package imgproc_pkg holds:
  - Register address constants: REG_STATUS=0, READ_MSG=1, READ_ID=2, REG_BBCOL=3.
  - FLUSH_BIT=4.
  - Default MSG_ID.
  - State enumeration.
- One natural sub-module: poll_timer (loadable down-counter with zero flag and hold input). Everything else stays in one FSM module.

## Test plan
- Slave model reports usedw=2, ID 32'h00524242, payload 32'h01F4_0001 -> exactly one msg_valid with distance=500, angle=0, detected=1. Read at address 1 issued exactly twice, never on consecutive cycles.
- usedw=0 on every poll -> a status read occurs every POLL_INTERVAL+2 cycles. No message reads, msg_valid never asserted.
- usedw=4 with two valid messages -> two msg_valid pulses 7 cycles apart, then a status read showing usedw=0, then IDLE.
- ID word 32'h0000_1234 -> no msg_valid. One write at address 0 with data 32'h10. resync_count=1.
- 256 forced mismatches -> resync_count stops at 8'hFF.
- reset_n low for one cycle during WT_ID -> next cycle shows all reset values, no msg_valid; the next poll resumes normally.
